// File: rtl/dff_pair_checker.sv
// Response checker for a two-stage D flip-flop DUT: tracks D history, compares Q1/Q2
// against it for NUM_CHECKS cycles and reports mismatch pulses, an error count and pass/fail.
module dff_pair_checker #(
  parameter int Q2_LAG      = 1,
  parameter int NUM_CHECKS  = 8,
  parameter int CNT_W       = 8,
  parameter bit STOP_ON_ERR = 1'b0
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             Enable,
  input  logic             D,
  input  logic             Q1,
  input  logic             Q2,
  output logic             err_q1,
  output logic             err_q2,
  output logic [CNT_W-1:0] err_cnt,
  output logic             busy,
  output logic             done,
  output logic             pass
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WARM,
    S_CHECK,
    S_DONE,
    S_FAIL
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] LAST_CHECK = CNT_W'(NUM_CHECKS - 1);
  localparam logic [1:0]       WARM_LAST  = 2'(Q2_LAG - 1);

  state_e             state_q, state_d;
  logic               h1_q, h2_q;
  logic [1:0]         warm_q, warm_d;
  logic [CNT_W-1:0]   chk_q, chk_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic               err_q1_q, err_q1_d;
  logic               err_q2_q, err_q2_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic               exp_q2;
  logic               mm_q1, mm_q2, any_mm;

  assign exp_q2 = (Q2_LAG == 1) ? h1_q : h2_q;

  // An X/Z on Q makes the equality unknown, so the if falls through and the cycle is flagged.
  always_comb begin
    mm_q1 = 1'b1;
    mm_q2 = 1'b1;
    if (Q1 == h1_q)   mm_q1 = 1'b0;
    if (Q2 == exp_q2) mm_q2 = 1'b0;
    any_mm = mm_q1 | mm_q2;
  end

  // NOTE: every variable gets a default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    warm_d    = warm_q;
    chk_d     = chk_q;
    err_cnt_d = err_cnt_q;
    err_q1_d  = 1'b0;
    err_q2_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (Enable) begin
          state_d   = S_WARM;
          warm_d    = '0;
          chk_d     = '0;
          err_cnt_d = '0;
        end
      end
      S_WARM: begin
        if (!Enable) begin
          state_d = S_IDLE;
        end else begin
          warm_d = warm_q + 2'd1;
          if (warm_q == WARM_LAST) state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (!Enable) begin
          state_d = S_IDLE;
        end else begin
          err_q1_d = mm_q1;
          err_q2_d = mm_q2;
          chk_d    = chk_q + 1'b1;
          if (any_mm && (err_cnt_q != CNT_MAX)) err_cnt_d = err_cnt_q + 1'b1;
          // A mismatch on the final compare still ends in FAIL when stopping on error.
          if (STOP_ON_ERR && any_mm)     state_d = S_FAIL;
          else if (chk_q == LAST_CHECK)  state_d = S_DONE;
        end
      end
      S_DONE, S_FAIL: begin
        if (!Enable) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_WARM) || (state_d == S_CHECK);
    done_d = (state_d == S_DONE) || (state_d == S_FAIL);
    pass_d = (state_d == S_DONE) && (err_cnt_d == '0);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values, mirroring real hardware regardless of statement order.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q   <= S_IDLE;
      h1_q      <= 1'b0;
      h2_q      <= 1'b0;
      warm_q    <= '0;
      chk_q     <= '0;
      err_cnt_q <= '0;
      err_q1_q  <= 1'b0;
      err_q2_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      h1_q      <= D;
      h2_q      <= h1_q;
      warm_q    <= warm_d;
      chk_q     <= chk_d;
      err_cnt_q <= err_cnt_d;
      err_q1_q  <= err_q1_d;
      err_q2_q  <= err_q2_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
    end
  end

  assign err_q1  = err_q1_q;
  assign err_q2  = err_q2_q;
  assign err_cnt = err_cnt_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = pass_q;

endmodule

// File: tb/tb_dff_pair_checker.sv
// Directed bench for dff_pair_checker: four checker instances watch good, pipelined,
// stuck-at and inverted flop pairs; expected error pulses flow through a scoreboard queue.
module tb_dff_pair_checker;

  typedef struct packed {
    logic e1;
    logic e2;
  } exp_t;

  logic Clock = 1'b0;
  logic Resetn;
  logic D;
  logic en_a, en_s, en_w, en_p;
  logic b_q1, b_q2, p_q1, p_q2;
  logic mode_pipe;
  logic a_q2, s_q1, w_q1, w_q2;

  logic       err1_a, err2_a, busy_a, done_a, pass_a;
  logic [7:0] cnt_a;
  logic       err1_s, err2_s, busy_s, done_s, pass_s;
  logic [7:0] cnt_s;
  logic       err1_w, err2_w, busy_w, done_w, pass_w;
  logic [1:0] cnt_w;
  logic       err1_p, err2_p, busy_p, done_p, pass_p;
  logic [7:0] cnt_p;

  int   checks   = 0;
  int   failures = 0;
  int   sel      = 0;
  logic dm1, dm2;
  logic obs1, obs2;
  exp_t sb_q[$];

  always #10 Clock = ~Clock;

  // Stand-in DUTs: a blocking-style pair (both stages load D) and a true pipeline.
  always @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      b_q1 <= 1'b0; b_q2 <= 1'b0; p_q1 <= 1'b0; p_q2 <= 1'b0;
    end else begin
      b_q1 <= D; b_q2 <= D; p_q1 <= D; p_q2 <= p_q1;
    end
  end

  assign a_q2 = mode_pipe ? p_q2 : b_q2;
  assign s_q1 = 1'b0;
  assign w_q1 = ~b_q1;
  assign w_q2 = ~b_q2;

  dff_pair_checker u_a (
    .Clock(Clock), .Resetn(Resetn), .Enable(en_a), .D(D), .Q1(b_q1), .Q2(a_q2),
    .err_q1(err1_a), .err_q2(err2_a), .err_cnt(cnt_a), .busy(busy_a), .done(done_a), .pass(pass_a));

  dff_pair_checker #(.STOP_ON_ERR(1'b1)) u_s (
    .Clock(Clock), .Resetn(Resetn), .Enable(en_s), .D(D), .Q1(s_q1), .Q2(b_q2),
    .err_q1(err1_s), .err_q2(err2_s), .err_cnt(cnt_s), .busy(busy_s), .done(done_s), .pass(pass_s));

  dff_pair_checker #(.CNT_W(2), .NUM_CHECKS(3)) u_w (
    .Clock(Clock), .Resetn(Resetn), .Enable(en_w), .D(D), .Q1(w_q1), .Q2(w_q2),
    .err_q1(err1_w), .err_q2(err2_w), .err_cnt(cnt_w), .busy(busy_w), .done(done_w), .pass(pass_w));

  dff_pair_checker #(.Q2_LAG(2)) u_p (
    .Clock(Clock), .Resetn(Resetn), .Enable(en_p), .D(D), .Q1(p_q1), .Q2(p_q2),
    .err_q1(err1_p), .err_q2(err2_p), .err_cnt(cnt_p), .busy(busy_p), .done(done_p), .pass(pass_p));

  always_comb begin
    obs1 = 1'b0;
    obs2 = 1'b0;
    case (sel)
      0:       begin obs1 = err1_a; obs2 = err2_a; end
      1:       begin obs1 = err1_s; obs2 = err2_s; end
      2:       begin obs1 = err1_w; obs2 = err2_w; end
      default: begin obs1 = err1_p; obs2 = err2_p; end
    endcase
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: toggle D, predict the pulses for this edge, then compare them after the edge.
  // dm1/dm2 hold D as sampled at the previous two edges.
  task automatic tick(input bit cmp, output bit mm);
    exp_t e;
    D = ~D;
    e = '0;
    if (cmp) begin
      case (sel)
        0:       e.e2 = mode_pipe ? (dm1 ^ dm2) : 1'b0;
        1:       e.e1 = dm1;
        2:       begin e.e1 = 1'b1; e.e2 = 1'b1; end
        default: e = '0;
      endcase
    end
    sb_q.push_back(e);
    @(posedge Clock);
    @(negedge Clock);
    e = sb_q.pop_front();
    check("err_q1", {7'd0, obs1}, {7'd0, e.e1});
    check("err_q2", {7'd0, obs2}, {7'd0, e.e2});
    mm  = e.e1 | e.e2;
    dm2 = dm1;
    dm1 = D;
  endtask

  initial begin
    bit mm;
    bit stop;
    int n_err;
    D = 1'b0; en_a = 1'b0; en_s = 1'b0; en_w = 1'b0; en_p = 1'b0;
    mode_pipe = 1'b0; dm1 = 1'b0; dm2 = 1'b0;
    Resetn = 1'b0;
    @(negedge Clock);
    check("rst_busy", {7'd0, busy_a}, 8'd0);
    check("rst_done", {7'd0, done_a}, 8'd0);
    check("rst_pass", {7'd0, pass_a}, 8'd0);
    check("rst_cnt", cnt_a, 8'd0);
    Resetn = 1'b1;
    tick(1'b0, mm);
    tick(1'b0, mm);

    // Good blocking-style pair: 1 warm + 8 compare cycles busy, then pass.
    sel = 0; mode_pipe = 1'b0; en_a = 1'b1;
    tick(1'b0, mm);
    check("good_busy_warm", {7'd0, busy_a}, 8'd1);
    tick(1'b0, mm);
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, mm);
      check("good_busy", {7'd0, busy_a}, (i < 7) ? 8'd1 : 8'd0);
      check("good_done", {7'd0, done_a}, (i == 7) ? 8'd1 : 8'd0);
    end
    check("good_pass", {7'd0, pass_a}, 8'd1);
    check("good_cnt", cnt_a, 8'd0);
    en_a = 1'b0;
    tick(1'b0, mm);
    check("good_idle_done", {7'd0, done_a}, 8'd0);

    // Pipelined pair judged as blocking-style: every toggle flags Q2.
    mode_pipe = 1'b1; en_a = 1'b1; n_err = 0;
    tick(1'b0, mm);
    tick(1'b0, mm);
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, mm);
      if (mm) n_err++;
    end
    check("pipe_done", {7'd0, done_a}, 8'd1);
    check("pipe_pass", {7'd0, pass_a}, 8'd0);
    check("pipe_cnt", cnt_a, 8'(n_err));
    en_a = 1'b0;
    tick(1'b0, mm);

    // Abort after 3 compares, then restart with a cleared count.
    en_a = 1'b1; n_err = 0;
    tick(1'b0, mm);
    tick(1'b0, mm);
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, mm);
      if (mm) n_err++;
    end
    en_a = 1'b0;
    tick(1'b0, mm);
    check("abort_busy", {7'd0, busy_a}, 8'd0);
    check("abort_done", {7'd0, done_a}, 8'd0);
    check("abort_cnt_held", cnt_a, 8'(n_err));
    en_a = 1'b1;
    tick(1'b0, mm);
    check("restart_cnt", cnt_a, 8'd0);
    check("restart_busy", {7'd0, busy_a}, 8'd1);
    tick(1'b0, mm);
    tick(1'b1, mm);
    tick(1'b1, mm);

    // Asynchronous reset in the middle of CHECK.
    #5 Resetn = 1'b0;
    #1;
    check("mid_rst_busy", {7'd0, busy_a}, 8'd0);
    check("mid_rst_cnt", cnt_a, 8'd0);
    check("mid_rst_err2", {7'd0, err2_a}, 8'd0);
    en_a = 1'b0; D = 1'b0; dm1 = 1'b0; dm2 = 1'b0;
    @(negedge Clock);
    Resetn = 1'b1;
    tick(1'b0, mm);
    check("post_rst_busy", {7'd0, busy_a}, 8'd0);
    check("post_rst_done", {7'd0, done_a}, 8'd0);

    // Q1 stuck at 0 with stop-on-error: first compare that expects a 1 ends in FAIL.
    sel = 1; en_s = 1'b1; stop = 1'b0;
    tick(1'b0, mm);
    tick(1'b0, mm);
    for (int i = 0; i < 4; i++) begin
      tick(!stop, mm);
      if (mm) stop = 1'b1;
    end
    check("stop_done", {7'd0, done_s}, 8'd1);
    check("stop_pass", {7'd0, pass_s}, 8'd0);
    check("stop_busy", {7'd0, busy_s}, 8'd0);
    check("stop_cnt", cnt_s, 8'd1);

    // Always-wrong pair on a 2-bit counter: count tops out at 3.
    sel = 2; en_w = 1'b1;
    tick(1'b0, mm);
    tick(1'b0, mm);
    for (int i = 0; i < 3; i++) tick(1'b1, mm);
    check("sat_done", {7'd0, done_w}, 8'd1);
    check("sat_pass", {7'd0, pass_w}, 8'd0);
    check("sat_cnt", {6'd0, cnt_w}, 8'd3);

    // Pipelined pair with the matching two-clock Q2 lag passes.
    sel = 3; en_p = 1'b1;
    tick(1'b0, mm);
    check("lag2_busy", {7'd0, busy_p}, 8'd1);
    tick(1'b0, mm);
    tick(1'b0, mm);
    for (int i = 0; i < 8; i++) tick(1'b1, mm);
    check("lag2_done", {7'd0, done_p}, 8'd1);
    check("lag2_pass", {7'd0, pass_p}, 8'd1);
    check("lag2_cnt", cnt_p, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
